ethernet_transmitter: RTL and testbench

ETHERNET_TRANSMITTER -- requirements
Module: ethernet_transmitter

---
 rtl/eth_pkg.sv | 26 ++
 rtl/tx_bit_timer.sv | 64 ++++++
 rtl/ethernet_transmitter.sv | 198 +++++++++++++++++++
 tb/tb_ethernet_transmitter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// -----------------------------------------------------------------------------
// eth_pkg
// Shared definitions for the Manchester Ethernet transmitter:
//   - eth_state_e      : transmitter FSM states
//   - PREAMBLE_BYTE    : byte repeated during the preamble (0xAA)
//   - SFD_BYTE         : start-of-frame delimiter (0xAB)
//   - DEFAULT_*        : default timing parameter values for the top level
// -----------------------------------------------------------------------------
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_IPG      = 3'd4
    } eth_state_e;

    localparam logic [7:0] PREAMBLE_BYTE = 8'hAA;
    localparam logic [7:0] SFD_BYTE      = 8'hAB;

    localparam int DEFAULT_HALF_BIT_CLKS  = 5;
    localparam int DEFAULT_PREAMBLE_BYTES = 7;
    localparam int DEFAULT_IPG_CLKS       = 20;

endpackage

// File: rtl/tx_bit_timer.sv
// -----------------------------------------------------------------------------
// tx_bit_timer
// Half-bit / bit timing for the Manchester line. While run=1 it counts
// HALF_BIT_CLKS clocks per half-bit and toggles the half-bit phase; while
// run=0 it parks at the start of a bit (count 0, first half).
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   run          : line is actively transmitting bits this cycle
//   bit_end      : this cycle is the last clock of the current bit
//   bit_end_nxt  : the next cycle will be the last clock of a bit
//   phase_nxt    : half-bit phase of the next cycle (0 = first half)
// -----------------------------------------------------------------------------
module tx_bit_timer #(
    parameter int HALF_BIT_CLKS = eth_pkg::DEFAULT_HALF_BIT_CLKS
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_end,
    output logic bit_end_nxt,
    output logic phase_nxt
);

    localparam int CW = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF_BIT_CLKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          half_end;

    assign half_end = run && (cnt_q == CNT_LAST);
    assign bit_end  = half_end && phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!run) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (half_end) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Look-ahead strobes let the top level register its outputs so they line
    // up with the cycle they describe.
    assign bit_end_nxt = (cnt_d == CNT_LAST) && phase_d;
    assign phase_nxt   = phase_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/ethernet_transmitter.sv
// -----------------------------------------------------------------------------
// ethernet_transmitter
// Sends a frame as Manchester-coded serial data, MSB first: PREAMBLE_BYTES
// bytes of 0xAA, one SFD byte 0xAB, then tx_len payload bytes popped from a
// first-word-fall-through FIFO, followed by an idle-high inter-packet gap.
// Bit 1 = low then high, bit 0 = high then low.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   tx_start      : single-cycle frame request (ignored while busy or len 0)
//   tx_len[10:0]  : payload byte count, sampled with tx_start
//   T_Data[7:0]   : FIFO head byte, valid while EMPTY=0
//   EMPTY         : FIFO empty flag
//   r_enable      : FIFO pop, high in the last cycle of the preceding byte
//   Ethernet_Out  : Manchester line, idle high
//   busy          : frame or IPG in progress
//   done          : pulse in the last IPG cycle
//   underrun      : pulse when the FIFO is empty at a payload fetch
//
// FIFO handshake: r_enable is a one-cycle pop; the FIFO presents the popped
// byte on T_Data during that cycle and advances at the closing clock edge,
// where the byte is captured into the shift register.
// -----------------------------------------------------------------------------
module ethernet_transmitter
    import eth_pkg::*;
#(
    parameter int HALF_BIT_CLKS  = DEFAULT_HALF_BIT_CLKS,
    parameter int PREAMBLE_BYTES = DEFAULT_PREAMBLE_BYTES,
    parameter int IPG_CLKS       = DEFAULT_IPG_CLKS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_start,
    input  logic [10:0] tx_len,
    input  logic [7:0]  T_Data,
    input  logic        EMPTY,
    output logic        r_enable,
    output logic        Ethernet_Out,
    output logic        busy,
    output logic        done,
    output logic        underrun
);

    localparam int PW = (PREAMBLE_BYTES > 1) ? $clog2(PREAMBLE_BYTES) : 1;
    localparam int IW = (IPG_CLKS > 1) ? $clog2(IPG_CLKS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_BYTES - 1);
    localparam logic [IW-1:0] IPG_LAST = IW'(IPG_CLKS - 1);

    eth_state_e    state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [10:0]   len_q, len_d;
    logic [IW-1:0] ipg_cnt_q, ipg_cnt_d;

    logic out_q, out_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic r_enable_q, r_enable_d;
    logic underrun_q, underrun_d;

    logic run, run_d, fetch_nxt;
    logic bit_end, bit_end_nxt, phase_nxt;

    assign run = (state_q == ST_PREAMBLE) || (state_q == ST_SFD) ||
                 (state_q == ST_PAYLOAD);

    tx_bit_timer #(
        .HALF_BIT_CLKS(HALF_BIT_CLKS)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .bit_end    (bit_end),
        .bit_end_nxt(bit_end_nxt),
        .phase_nxt  (phase_nxt)
    );

    // Next-state logic: FSM, shift register, byte counters.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        pre_cnt_d = pre_cnt_q;
        len_d     = len_q;
        ipg_cnt_d = ipg_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (tx_start && (tx_len != 11'd0)) begin
                    state_d   = ST_PREAMBLE;
                    shift_d   = PREAMBLE_BYTE;
                    bit_cnt_d = 3'd0;
                    pre_cnt_d = '0;
                    len_d     = tx_len;
                end
            end

            ST_PREAMBLE, ST_SFD, ST_PAYLOAD: begin
                if (bit_end) begin
                    if (bit_cnt_q != 3'd7) begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else begin
                        bit_cnt_d = 3'd0;
                        if (state_q == ST_PREAMBLE) begin
                            if (pre_cnt_q == PRE_LAST) begin
                                state_d   = ST_SFD;
                                shift_d   = SFD_BYTE;
                                pre_cnt_d = '0;
                            end else begin
                                shift_d   = PREAMBLE_BYTE;
                                pre_cnt_d = pre_cnt_q + 1'b1;
                            end
                        end else if (r_enable_q) begin
                            // The pop is in flight this cycle: T_Data is the
                            // next payload byte.
                            state_d = ST_PAYLOAD;
                            shift_d = T_Data;
                            len_d   = len_q - 11'd1;
                        end else begin
                            // Either all bytes are out or the FIFO underran.
                            state_d   = ST_IPG;
                            shift_d   = 8'h00;
                            ipg_cnt_d = '0;
                        end
                    end
                end
            end

            ST_IPG: begin
                if (ipg_cnt_q == IPG_LAST) begin
                    state_d   = ST_IDLE;
                    ipg_cnt_d = '0;
                    len_d     = 11'd0;
                end else begin
                    ipg_cnt_d = ipg_cnt_q + 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next-cycle view, so each output bit
    // describes the cycle in which it is visible.
    always_comb begin
        run_d = (state_d == ST_PREAMBLE) || (state_d == ST_SFD) ||
                (state_d == ST_PAYLOAD);
        out_d = run_d ? (phase_nxt ? shift_d[7] : ~shift_d[7]) : 1'b1;

        // A fetch happens in the last cycle of an SFD or payload byte while
        // payload bytes remain. The FIFO is only drained by us, so a non-empty
        // flag seen one cycle ahead still holds in the fetch cycle.
        fetch_nxt = ((state_d == ST_SFD) || (state_d == ST_PAYLOAD)) &&
                    (bit_cnt_d == 3'd7) && bit_end_nxt && (len_d != 11'd0);
        r_enable_d = fetch_nxt && !EMPTY;
        underrun_d = fetch_nxt && EMPTY;

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_IPG) && (ipg_cnt_d == IPG_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            pre_cnt_q  <= '0;
            len_q      <= 11'd0;
            ipg_cnt_q  <= '0;
            out_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            r_enable_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            pre_cnt_q  <= pre_cnt_d;
            len_q      <= len_d;
            ipg_cnt_q  <= ipg_cnt_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            r_enable_q <= r_enable_d;
            underrun_q <= underrun_d;
        end
    end

    assign Ethernet_Out = out_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign r_enable     = r_enable_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_ethernet_transmitter.sv
// -----------------------------------------------------------------------------
// tb_ethernet_transmitter
// Directed bench for ethernet_transmitter with default parameters
// (5 clocks per half-bit, 7 preamble bytes, 20 IPG clocks). A small FIFO
// model feeds the DUT; the line is recorded per cycle and decoded back into
// bytes, which are compared against an expected byte queue.
// -----------------------------------------------------------------------------
module tb_ethernet_transmitter;

    logic        clk;
    logic        rst;
    logic        tx_start;
    logic [10:0] tx_len;
    logic [7:0]  T_Data;
    logic        EMPTY;
    logic        r_enable;
    logic        Ethernet_Out;
    logic        busy;
    logic        done;
    logic        underrun;

    ethernet_transmitter dut (
        .clk         (clk),
        .rst         (rst),
        .tx_start    (tx_start),
        .tx_len      (tx_len),
        .T_Data      (T_Data),
        .EMPTY       (EMPTY),
        .r_enable    (r_enable),
        .Ethernet_Out(Ethernet_Out),
        .busy        (busy),
        .done        (done),
        .underrun    (underrun)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- FIFO model ----------------
    logic [7:0] fifo_mem [0:63];
    int         fifo_wr = 0;
    int         fifo_rd = 0;

    assign EMPTY  = (fifo_rd == fifo_wr);
    assign T_Data = fifo_mem[fifo_rd % 64];

    always @(posedge clk) begin
        if (r_enable && (fifo_rd != fifo_wr)) fifo_rd <= fifo_rd + 1;
    end

    task automatic fifo_push(input logic [7:0] b);
        fifo_mem[fifo_wr % 64] = b;
        fifo_wr = fifo_wr + 1;
    endtask

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input int n_payload, input logic [7:0] pay0,
                              input logic [7:0] pay1);
        for (int i = 0; i < 7; i++) exp_q.push_back(8'hAA);
        exp_q.push_back(8'hAB);
        for (int i = 0; i < n_payload; i++)
            exp_q.push_back((i % 2 == 0) ? pay0 : pay1);
    endtask

    // ---------------- line recorder ----------------
    logic line_bits [0:2047];
    int   ren_cnt, ren_first, und_cnt, und_cyc, done_cyc, busy_low;

    // Decode byte k of the recorded frame; -1 on a Manchester violation.
    function automatic int decode_byte(input int k);
        int   v;
        int   base;
        logic h0, h1;
        v = 0;
        for (int i = 0; i < 8; i++) begin
            base = 1 + k * 80 + i * 10;
            h0 = line_bits[base];
            h1 = line_bits[base + 5];
            for (int j = 0; j < 5; j++) begin
                if (line_bits[base + j] !== h0) return -1;
                if (line_bits[base + 5 + j] !== h1) return -1;
            end
            if (h0 === h1) return -1;
            v = (v << 1) | (h1 ? 1 : 0);
        end
        return v;
    endfunction

    // Called at a negedge. Cycle c is the c-th cycle after the edge that
    // samples tx_start. inj_cycle>0 pulses an extra tx_start in that cycle.
    task automatic run_frame(input int len, input int inj_cycle);
        ren_cnt = 0; ren_first = 0; und_cnt = 0; und_cyc = 0;
        done_cyc = 0; busy_low = 0;
        tx_len   = 11'(len);
        tx_start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 1200; c++) begin
            @(negedge clk);
            tx_start = (c == inj_cycle);
            if (c == inj_cycle) tx_len = 11'd5;
            line_bits[c] = Ethernet_Out;
            if (r_enable) begin
                ren_cnt++;
                if (ren_first == 0) ren_first = c;
            end
            if (underrun) begin
                und_cnt++;
                und_cyc = c;
            end
            if (!busy) busy_low++;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        tx_start = 1'b0;
        check_eq("done_seen", done_cyc != 0, 1);
        @(negedge clk);
        check_eq("busy_after_done", busy, 1'b0);
    endtask

    // Compares decoded bytes against exp_q and checks the gap is idle high.
    task automatic check_frame(input string name, input int n_bytes);
        int got;
        int ipg_low;
        for (int k = 0; k < n_bytes; k++) begin
            got = decode_byte(k);
            if (exp_q.size() == 0) begin
                check_eq($sformatf("%s_extra_byte%0d", name, k), got, 32'hFFFF_FFFF);
            end else begin
                check_eq($sformatf("%s_byte%0d", name, k), got, {24'd0, exp_q.pop_front()});
            end
        end
        check_eq($sformatf("%s_exp_left", name), exp_q.size(), 0);
        ipg_low = 0;
        for (int c = n_bytes * 80 + 1; c <= done_cyc; c++)
            if (line_bits[c] !== 1'b1) ipg_low++;
        check_eq($sformatf("%s_ipg_low", name), ipg_low, 0);
        check_eq($sformatf("%s_busy_low", name), busy_low, 0);
    endtask

    // ---------------- test sequence ----------------
    int line_low, ren_seen, busy_seen;

    initial begin
        rst      = 1'b1;
        tx_start = 1'b0;
        tx_len   = 11'd0;

        // Reset held for 2 cycles.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("rst_line", Ethernet_Out, 1'b1);
            check_eq("rst_busy", busy, 1'b0);
            check_eq("rst_ren", r_enable, 1'b0);
            check_eq("rst_done", done, 1'b0);
            check_eq("rst_underrun", underrun, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Nominal: 4 x 0x0F.
        for (int i = 0; i < 4; i++) fifo_push(8'h0F);
        push_frame(4, 8'h0F, 8'h0F);
        run_frame(4, 0);
        check_eq("nom_done_cycle", done_cyc, 980);
        check_eq("nom_ren_cnt", ren_cnt, 4);
        check_eq("nom_ren_first", ren_first, 640);
        check_eq("nom_underrun", und_cnt, 0);
        check_frame("nom", 12);

        // Zero-length start in IDLE is ignored, even with FIFO data waiting.
        fifo_push(8'hFB);
        tx_len   = 11'd0;
        tx_start = 1'b1;
        line_low = 0; ren_seen = 0; busy_seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            tx_start = 1'b0;
            if (Ethernet_Out !== 1'b1) line_low++;
            if (r_enable) ren_seen++;
            if (busy) busy_seen++;
        end
        check_eq("len0_line_low", line_low, 0);
        check_eq("len0_ren", ren_seen, 0);
        check_eq("len0_busy", busy_seen, 0);

        // Loopback frame of 0xFB bytes with a stray tx_start during payload.
        fifo_push(8'hFB);
        fifo_push(8'hFB);
        push_frame(3, 8'hFB, 8'hFB);
        run_frame(3, 700);
        check_eq("lb_done_cycle", done_cyc, 900);
        check_eq("lb_ren_cnt", ren_cnt, 3);
        check_eq("lb_underrun", und_cnt, 0);
        check_frame("lb", 11);
        check_eq("lb_fifo_empty", EMPTY, 1'b1);

        // Underrun: 2 bytes available, 4 requested.
        fifo_push(8'h3C);
        fifo_push(8'hC3);
        push_frame(2, 8'h3C, 8'hC3);
        run_frame(4, 0);
        check_eq("und_ren_cnt", ren_cnt, 2);
        check_eq("und_cnt", und_cnt, 1);
        check_eq("und_cycle", und_cyc, 800);
        check_eq("und_done_cycle", done_cyc, 820);
        check_frame("und", 10);

        // Mid-frame reset during payload, then a 1-byte frame.
        fifo_push(8'h11);
        fifo_push(8'h22);
        tx_len   = 11'd2;
        tx_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_start = 1'b0;
        repeat (699) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_line", Ethernet_Out, 1'b1);
        check_eq("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        check_eq("mid_rst_ren", r_enable, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        // 0x11 was popped before the reset; 0x22 is still at the FIFO head.
        push_frame(1, 8'h22, 8'h22);
        run_frame(1, 0);
        check_eq("post_rst_done_cycle", done_cyc, 740);
        check_eq("post_rst_ren_cnt", ren_cnt, 1);
        check_frame("post_rst", 9);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
